sd_cmd_framer: RTL and testbench



---
 rtl/sd_cmd_framer_pkg.sv | 58 +++++
 rtl/sd_cmd_framer_if.sv | 24 ++
 rtl/sd_cmd_framer_crc7.sv | 29 ++
 rtl/sd_cmd_framer.sv | 173 +++++++++++++++++
 tb/tb_sd_cmd_framer.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_cmd_framer_pkg.sv
// Shared types and constants for the SD SPI-mode command framer.
// Package name: sd_cmd_pkg. Optional CRC7 generation is selected by SD_CMD_CRC7_EN.
package sd_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        FRAME,
        POST,
        DONE
    } state_t;

    localparam logic [6:0] CRC7_POLY = 7'h09;

    localparam logic [5:0] CMD_GO_IDLE      = 6'd0;
    localparam logic [5:0] CMD_SEND_IF_COND = 6'd8;
    localparam logic [5:0] CMD_READ_SINGLE  = 6'd17;
    localparam logic [5:0] CMD_READ_MULTI   = 6'd18;
    localparam logic [5:0] CMD_WRITE_SINGLE = 6'd24;
    localparam logic [5:0] CMD_WRITE_MULTI  = 6'd25;
    localparam logic [5:0] CMD_READ_OCR     = 6'd58;

    localparam int FRAME_LEN = 6;

    // Precomputed trailer bytes ({crc7,1}) for the commands that need a valid CRC
    // before the card leaves native mode; anything else gets a dummy trailer.
    localparam logic [7:0] CRC_BYTE_GO_IDLE = 8'h95;
    localparam logic [7:0] CRC_BYTE_IF_COND = 8'h87;
    localparam logic [7:0] CRC_BYTE_DUMMY   = 8'h01;

    // Commands whose argument is a block address and may need byte scaling.
    function automatic logic is_addr_cmd(input logic [5:0] idx);
        return (idx == CMD_READ_SINGLE)  || (idx == CMD_READ_MULTI) ||
               (idx == CMD_WRITE_SINGLE) || (idx == CMD_WRITE_MULTI);
    endfunction

    // Fixed trailer used when CRC generation is compiled out.
    function automatic logic [7:0] fixed_crc_byte(input logic [5:0] idx);
        case (idx)
            CMD_GO_IDLE:      return CRC_BYTE_GO_IDLE;
            CMD_SEND_IF_COND: return CRC_BYTE_IF_COND;
            default:          return CRC_BYTE_DUMMY;
        endcase
    endfunction

    // One byte of CRC7 (x^7+x^3+1), MSB first.
    function automatic logic [6:0] crc7_byte(input logic [6:0] crc, input logic [7:0] data);
        logic [6:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ data[i];
            c  = {c[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
        return c;
    endfunction

endpackage

// File: rtl/sd_cmd_framer_if.sv
// Command request / byte-stream bundle between the SD controller FSM,
// the command framer and the SPI byte shifter.
interface sd_cmd_framer_if;
    logic        cmd_start;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        cmd_done;

    // Controller / shifter side.
    modport master (
        output cmd_start, cmd_index, cmd_arg, tx_ready,
        input  tx_byte, tx_valid, busy, cmd_done
    );

    // Framer side.
    modport slave (
        input  cmd_start, cmd_index, cmd_arg, tx_ready,
        output tx_byte, tx_valid, busy, cmd_done
    );
endinterface

// File: rtl/sd_cmd_framer_crc7.sv
// Bytewise CRC7 accumulator (x^7+x^3+1, init 0, MSB first) for the command framer.
// Only compiled when SD_CMD_CRC7_EN is defined, since only then is it instantiated.
`ifdef SD_CMD_CRC7_EN
module sd_crc7
    import sd_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] data,
    output logic [6:0] crc
);
    logic [6:0] r_crc;

    // Accumulate one byte per enabled cycle; clear has priority for a new command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc <= 7'h00;
        end else if (clr) begin
            r_crc <= 7'h00;
        end else if (en) begin
            r_crc <= crc7_byte(r_crc, data);
        end
    end

    assign crc = r_crc;
endmodule
`endif

// File: rtl/sd_cmd_framer.sv
// SD SPI-mode command framer: latches a command index and argument and streams
// [PRE_FF x 0xFF] {01,idx} arg[31:0] {crc7,1} [POST_FF x 0xFF] over valid/ready.
// Define SD_CMD_CRC7_EN to compute CRC7; otherwise the trailer comes from a table.
module sd_cmd_framer
    import sd_cmd_pkg::*;
#(
    parameter int PRE_FF     = 1,
    parameter int POST_FF    = 1,
    parameter int ADDR_SHIFT = 0
) (
    input  logic          clk,
    input  logic          rst,
    sd_cmd_framer_if.slave bus
);
    if (PRE_FF < 0 || PRE_FF > 15) begin : g_bad_pre_ff
        $error("sd_cmd_framer: PRE_FF must be within 0..15");
    end
    if (POST_FF < 0 || POST_FF > 15) begin : g_bad_post_ff
        $error("sd_cmd_framer: POST_FF must be within 0..15");
    end

    localparam logic [3:0] PRE_LAST   = 4'(PRE_FF - 1);
    localparam logic [3:0] POST_LAST  = 4'(POST_FF - 1);
    localparam logic [3:0] FRAME_LAST = 4'(FRAME_LEN - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        r_armed;      // high from the second cycle of a send sequence
    logic        w_armed_nxt;
    logic [5:0]  r_idx;
    logic [31:0] r_arg;

    logic        w_start;
    logic        w_sending;
    logic        w_valid;
    logic        w_xfer;
    logic [31:0] w_arg_eff;
    logic [7:0]  w_byte;
    logic [7:0]  w_crc_byte;

    assign w_start   = (r_state == IDLE) && bus.cmd_start;
    assign w_sending = (r_state == PRE) || (r_state == FRAME) || (r_state == POST);
    assign w_valid   = w_sending && r_armed;
    assign w_xfer    = w_valid && bus.tx_ready;
    assign w_arg_eff = is_addr_cmd(bus.cmd_index) ? (bus.cmd_arg << ADDR_SHIFT) : bus.cmd_arg;

`ifdef SD_CMD_CRC7_EN
    logic [6:0] w_crc;
    logic       w_crc_en;

    // Bytes 0..4 feed the CRC as they are accepted, so it is final before byte 5.
    assign w_crc_en = w_xfer && (r_state == FRAME) && (r_cnt < FRAME_LAST);

    sd_crc7 u_crc7 (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_start),
        .en   (w_crc_en),
        .data (w_byte),
        .crc  (w_crc)
    );

    assign w_crc_byte = {w_crc, 1'b1};
`else
    assign w_crc_byte = fixed_crc_byte(r_idx);
`endif

    // State, counter and latched command registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_armed <= 1'b0;
            // NOTE: the latched command is reset as well so tx_byte never carries X,
            // even though it is always rewritten before use.
            r_idx   <= 6'd0;
            r_arg   <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments here so every register updates from
            // pre-edge values regardless of statement order.
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_armed <= w_armed_nxt;
            if (w_start) begin
                r_idx <= bus.cmd_index;
                r_arg <= w_arg_eff;
            end
        end
    end

    // Next-state logic: advance the byte counter on each accepted byte.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_armed_nxt = r_armed;
        case (r_state)
            IDLE: begin
                w_armed_nxt = 1'b0;
                if (w_start) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = (PRE_FF > 0) ? PRE : FRAME;
                end
            end
            PRE: begin
                w_armed_nxt = 1'b1;
                if (w_xfer) begin
                    if (r_cnt == PRE_LAST) begin
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = FRAME;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
            end
            FRAME: begin
                w_armed_nxt = 1'b1;
                if (w_xfer) begin
                    if (r_cnt == FRAME_LAST) begin
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = (POST_FF > 0) ? POST : DONE;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
            end
            POST: begin
                w_armed_nxt = 1'b1;
                if (w_xfer) begin
                    if (r_cnt == POST_LAST) begin
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = DONE;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
            end
            DONE: begin
                w_armed_nxt = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_armed_nxt = 1'b0;
                w_cnt_nxt   = 4'd0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outgoing byte: frame content in FRAME, 0xFF fill otherwise or when not valid.
    always_comb begin
        w_byte = 8'hFF;
        if (w_valid && (r_state == FRAME)) begin
            case (r_cnt)
                4'd0:    w_byte = {2'b01, r_idx};
                4'd1:    w_byte = r_arg[31:24];
                4'd2:    w_byte = r_arg[23:16];
                4'd3:    w_byte = r_arg[15:8];
                4'd4:    w_byte = r_arg[7:0];
                4'd5:    w_byte = w_crc_byte;
                default: w_byte = 8'hFF;
            endcase
        end
    end

    assign bus.tx_byte  = w_byte;
    assign bus.tx_valid = w_valid;
    assign bus.busy     = (r_state != IDLE);
    assign bus.cmd_done = (r_state == DONE);

endmodule

// File: tb/tb_sd_cmd_framer.sv
// Self-checking bench for sd_cmd_framer. Instance A uses default parameters
// (PRE_FF=1, POST_FF=1, ADDR_SHIFT=0); instance B uses PRE_FF=0, POST_FF=2, ADDR_SHIFT=9.
// CRC-specific expectations follow SD_CMD_CRC7_EN.
module tb_sd_cmd_framer;
    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        bit          sel;      // 0: instance A, 1: instance B
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [39:0] hdr;      // expected frame bytes 0..4
        logic [7:0]  b5_crc;   // expected byte 5 when CRC is generated
        bit          b5_known; // b5_crc holds a hand-known constant
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    sd_cmd_framer_if if_a ();
    sd_cmd_framer_if if_b ();

    sd_cmd_framer u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    sd_cmd_framer #(
        .PRE_FF     (0),
        .POST_FF    (2),
        .ADDR_SHIFT (9)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // CRC7 as the remainder of msg*x^7 divided by x^7+x^3+1 (polynomial long division).
    function automatic logic [6:0] ref_crc7(input logic [39:0] msg);
        logic [46:0] rem;
        rem = {msg, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (rem[i]) rem[i -: 8] = rem[i -: 8] ^ 8'h89;
        end
        return rem[6:0];
    endfunction

    function automatic logic [7:0] tab_b5(input logic [5:0] idx);
        if (idx == 6'd0) return 8'h95;
        if (idx == 6'd8) return 8'h87;
        return 8'h01;
    endfunction

    function automatic int pre_of(input bit sel);
        return sel ? 0 : 1;
    endfunction

    function automatic int post_of(input bit sel);
        return sel ? 2 : 1;
    endfunction

    function automatic byte_q_t wrap(input bit sel, input logic [39:0] hdr, input logic [7:0] b5);
        byte_q_t q;
        q = {};
        repeat (pre_of(sel)) q.push_back(8'hFF);
        for (int k = 4; k >= 0; k--) q.push_back(hdr[k*8 +: 8]);
        q.push_back(b5);
        repeat (post_of(sel)) q.push_back(8'hFF);
        return q;
    endfunction

    function automatic byte_q_t ref_stream(input bit sel, input logic [5:0] idx, input logic [31:0] arg);
        int          shift;
        logic [31:0] a;
        logic [39:0] m;
        logic [7:0]  b5;
        shift = sel ? 9 : 0;
        a = (idx inside {6'd17, 6'd18, 6'd24, 6'd25}) ? (arg << shift) : arg;
        m = {2'b01, idx, a};
`ifdef SD_CMD_CRC7_EN
        b5 = {ref_crc7(m), 1'b1};
`else
        b5 = tab_b5(idx);
`endif
        return wrap(sel, m, b5);
    endfunction

    // ---------------- pin access ----------------
    task automatic set_start(input bit sel, input logic v, input logic [5:0] idx, input logic [31:0] arg);
        if (!sel) begin
            if_a.cmd_start = v; if_a.cmd_index = idx; if_a.cmd_arg = arg;
        end else begin
            if_b.cmd_start = v; if_b.cmd_index = idx; if_b.cmd_arg = arg;
        end
    endtask

    task automatic set_ready(input bit sel, input logic r);
        if (!sel) if_a.tx_ready = r;
        else      if_b.tx_ready = r;
    endtask

    function automatic logic get_valid(input bit sel);
        return sel ? if_b.tx_valid : if_a.tx_valid;
    endfunction
    function automatic logic [7:0] get_byte(input bit sel);
        return sel ? if_b.tx_byte : if_a.tx_byte;
    endfunction
    function automatic logic get_busy(input bit sel);
        return sel ? if_b.busy : if_a.busy;
    endfunction
    function automatic logic get_done(input bit sel);
        return sel ? if_b.cmd_done : if_a.cmd_done;
    endfunction

    // Issue one command and collect accepted bytes. All sampling and driving on negedge.
    task automatic run_cmd(
        input  bit          sel,
        input  logic [5:0]  idx,
        input  logic [31:0] arg,
        input  int          rdy_pct,
        input  bit          poke,
        output byte_q_t     got,
        output int          n_done,
        output int          proto_err,
        output int          first_x,
        output int          last_x,
        output int          done_cyc,
        output logic        busy_start,
        output logic        busy_after,
        output logic        busy_late
    );
        logic       v, r, prev_stall;
        logic [7:0] b, prev_b;
        int         poke_cyc;
        got = {}; n_done = 0; proto_err = 0; first_x = -1; last_x = -1; done_cyc = -1;
        busy_after = 1'b1; busy_late = 1'b1; prev_stall = 1'b0; prev_b = 8'hFF;
        poke_cyc = $urandom_range(6, 1);
        @(negedge clk);
        set_start(sel, 1'b1, idx, arg);
        set_ready(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0, 6'd0, 32'd0);
        busy_start = get_busy(sel);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            v = get_valid(sel);
            b = get_byte(sel);
            if (prev_stall && (!v || b != prev_b)) proto_err++;
            if (!v && b != 8'hFF) proto_err++;
            if (get_done(sel)) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = get_busy(sel);
            if (done_cyc >= 0 && cyc == done_cyc + 4) begin
                busy_late = get_busy(sel);
                break;
            end
            r = ($urandom_range(99) < rdy_pct);
            set_ready(sel, r);
            set_start(sel, poke && (cyc == poke_cyc), 6'h2A, $urandom);
            if (v && r) begin
                got.push_back(b);
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
            end
            prev_stall = v && !r;
            prev_b = b;
            @(negedge clk);
        end
        set_ready(sel, 1'b1);
    endtask

    task automatic cmp_stream(input string tag, input byte_q_t got, input byte_q_t exp);
        check({tag, "_len"}, got.size(), exp.size());
        for (int k = 0; k < exp.size(); k++) begin
            check($sformatf("%s_byte%0d", tag, k),
                  (k < got.size()) ? {24'd0, got[k]} : 32'h100, {24'd0, exp[k]});
        end
    endtask

    initial begin
        vec_t       vecs[$];
        byte_q_t    got, exp;
        int         n_done, proto_err, first_x, last_x, done_cyc, n_seen;
        logic       busy_start, busy_after, busy_late;
        logic [7:0] b5;
        bit         sel;
        logic [5:0] idx;
        logic [31:0] arg;
        int         mism;

        set_start(1'b0, 1'b0, 6'd0, 32'd0);
        set_start(1'b1, 1'b0, 6'd0, 32'd0);
        set_ready(1'b0, 1'b1);
        set_ready(1'b1, 1'b1);

        // Reset state
        @(negedge clk);
        check("rst_valid_a", if_a.tx_valid, 0);
        check("rst_byte_a", if_a.tx_byte, 8'hFF);
        check("rst_busy_a", if_a.busy, 0);
        check("rst_done_a", if_a.cmd_done, 0);
        check("rst_valid_b", if_b.tx_valid, 0);
        check("rst_busy_b", if_b.busy, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors, tx_ready held high
        vecs = '{
            '{1'b0, 6'd0,  32'h0000_0000, 40'h40_0000_0000, 8'h95, 1'b1},
            '{1'b0, 6'd8,  32'h0000_01AA, 40'h48_0000_01AA, 8'h87, 1'b1},
            '{1'b0, 6'd17, 32'h0000_0000, 40'h51_0000_0000, 8'h55, 1'b1},
            '{1'b0, 6'd58, 32'h0000_0000, 40'h7A_0000_0000, 8'hFD, 1'b1},
            '{1'b0, 6'd24, 32'h1234_5678, 40'h58_1234_5678, 8'h00, 1'b0},
            '{1'b1, 6'd17, 32'h0000_0003, 40'h51_0000_0600, 8'h00, 1'b0},
            '{1'b1, 6'd8,  32'h0000_0003, 40'h48_0000_0003, 8'h00, 1'b0},
            '{1'b1, 6'd18, 32'h0000_0001, 40'h52_0000_0200, 8'h00, 1'b0},
            '{1'b1, 6'd24, 32'h8000_0001, 40'h58_0000_0200, 8'h00, 1'b0},
            '{1'b1, 6'd25, 32'hFFFF_FFFF, 40'h59_FFFF_FE00, 8'h00, 1'b0},
            '{1'b1, 6'd0,  32'h0000_0000, 40'h40_0000_0000, 8'h95, 1'b1}
        };
        foreach (vecs[i]) begin
`ifdef SD_CMD_CRC7_EN
            b5 = vecs[i].b5_known ? vecs[i].b5_crc : {ref_crc7(vecs[i].hdr), 1'b1};
`else
            b5 = tab_b5(vecs[i].idx);
`endif
            exp = wrap(vecs[i].sel, vecs[i].hdr, b5);
            run_cmd(vecs[i].sel, vecs[i].idx, vecs[i].arg, 100, 1'b0, got, n_done, proto_err,
                    first_x, last_x, done_cyc, busy_start, busy_after, busy_late);
            cmp_stream($sformatf("vec%0d", i), got, exp);
            check($sformatf("vec%0d_busy_start", i), busy_start, 1);
            check($sformatf("vec%0d_first_valid_cyc", i), first_x, 1);
            check($sformatf("vec%0d_back_to_back", i), last_x - first_x, exp.size() - 1);
            check($sformatf("vec%0d_done_cyc", i), done_cyc, last_x + 1);
            check($sformatf("vec%0d_done_pulses", i), n_done, 1);
            check($sformatf("vec%0d_busy_after_done", i), busy_after, 0);
            check($sformatf("vec%0d_proto", i), proto_err, 0);
        end

        // Reset mid-frame on A, after frame byte 2 is accepted
        @(negedge clk);
        set_start(1'b0, 1'b1, 6'd0, 32'h0);
        set_ready(1'b0, 1'b1);
        @(negedge clk);
        set_start(1'b0, 1'b0, 6'd0, 32'h0);
        n_seen = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (if_a.tx_valid) n_seen++;
            if (n_seen == 4) break;
            @(negedge clk);
        end
        check("midrst_reached_byte2", n_seen, 4);
        @(posedge clk);
        #2;
        check("midrst_busy_before", if_a.busy, 1);
        rst = 1'b1;
        #1;
        check("midrst_valid", if_a.tx_valid, 0);
        check("midrst_byte", if_a.tx_byte, 8'hFF);
        check("midrst_busy", if_a.busy, 0);
        check("midrst_done", if_a.cmd_done, 0);
        @(negedge clk);
        rst = 1'b0;
        run_cmd(1'b0, 6'd0, 32'h0, 100, 1'b0, got, n_done, proto_err,
                first_x, last_x, done_cyc, busy_start, busy_after, busy_late);
        cmp_stream("after_rst", got, ref_stream(1'b0, 6'd0, 32'h0));
        check("after_rst_done_pulses", n_done, 1);

        // Random commands, random tx_ready stalls, stray start pulses while busy
        for (int t = 0; t < 24; t++) begin
            sel = 1'($urandom_range(1));
            if ($urandom_range(2) == 0) begin
                case ($urandom_range(3))
                    0: idx = 6'd17;
                    1: idx = 6'd18;
                    2: idx = 6'd24;
                    default: idx = 6'd25;
                endcase
            end else begin
                idx = 6'($urandom);
            end
            arg = $urandom;
            exp = ref_stream(sel, idx, arg);
            run_cmd(sel, idx, arg, 50, 1'b1, got, n_done, proto_err,
                    first_x, last_x, done_cyc, busy_start, busy_after, busy_late);
            mism = (got.size() != exp.size()) ? 1 : 0;
            for (int k = 0; k < exp.size() && k < got.size(); k++) begin
                if (got[k] !== exp[k]) mism++;
            end
            check($sformatf("rnd%0d_stream_mismatches(sel=%0d idx=%0d arg=%0h)", t, sel, idx, arg), mism, 0);
            check($sformatf("rnd%0d_done_pulses", t), n_done, 1);
            check($sformatf("rnd%0d_stall_hold", t), proto_err, 0);
            check($sformatf("rnd%0d_busy_after_done", t), busy_after, 0);
            check($sformatf("rnd%0d_no_queued_start", t), busy_late, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
